// File: rtl/aes_pkg.sv
// Shared cipher datapath types and the AddRoundKey helper.
package aes_pkg;

   localparam int unsigned NB_DEF     = 4;
   localparam int unsigned WORD_W_DEF = 32;

   typedef logic [WORD_W_DEF-1:0] word_t;
   typedef word_t [NB_DEF-1:0]    state_t;

   function automatic state_t ark_xor(state_t s, state_t k);
      state_t r;
      for (int i = 0; i < int'(NB_DEF); i++) begin
         r[i] = s[i] ^ k[i];
      end
      return r;
   endfunction

endpackage

// File: rtl/ark_skid.sv
// Generic 2-entry valid/ready skid buffer; main entry drives the outputs,
// in_ready is registered so there is no combinational path from out_ready.
module ark_skid #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic [1:0]   cnt_q, cnt_d;
   logic [W-1:0] main_q, main_d;
   logic [W-1:0] skid_q, skid_d;
   logic         rdy_q;
   logic         push, pop;

   assign push      = in_valid & rdy_q;
   assign pop       = (cnt_q != 2'd0) & out_ready;
   assign in_ready  = rdy_q;
   assign out_valid = (cnt_q != 2'd0);
   assign out_data  = main_q;

   always_comb begin
      cnt_d  = cnt_q;
      main_d = main_q;
      skid_d = skid_q;
      case (cnt_q)
         2'd0: begin
            if (push) begin
               main_d = in_data;
               cnt_d  = 2'd1;
            end
         end
         2'd1: begin
            if (push && pop) begin
               main_d = in_data;
            end else if (push) begin
               skid_d = in_data;
               cnt_d  = 2'd2;
            end else if (pop) begin
               cnt_d = 2'd0;
            end
         end
         2'd2: begin
            // Full: in_ready is low, so only a pop can happen here.
            if (pop) begin
               main_d = skid_q;
               cnt_d  = 2'd1;
            end
         end
         default: cnt_d = 2'd0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= 2'd0;
         main_q <= '0;
         skid_q <= '0;
         rdy_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         main_q <= main_d;
         skid_q <= skid_d;
         rdy_q  <= (cnt_d != 2'd2);
      end
   end

endmodule

// File: rtl/ark_stage.sv
// Registered AddRoundKey stage with skid buffering. Define ARK_BYPASS_EN to
// add bypass_i, which stores state_i unmodified instead of state_i ^ rk_i.
module ark_stage
   import aes_pkg::*;
#(
   parameter int unsigned NB     = NB_DEF,
   parameter int unsigned WORD_W = WORD_W_DEF,
   parameter int unsigned TAG_W  = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [NB-1:0][WORD_W-1:0]  state_i,
   input  logic [NB-1:0][WORD_W-1:0]  rk_i,
   input  logic [TAG_W-1:0]           tag_i,
`ifdef ARK_BYPASS_EN
   input  logic                       bypass_i,
`endif
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [NB-1:0][WORD_W-1:0]  state_o,
   output logic [TAG_W-1:0]           tag_o,
   output logic                       zero_o
);

   localparam int unsigned SW = NB * WORD_W;
   localparam int unsigned PW = SW + TAG_W + 1;

   logic [NB-1:0][WORD_W-1:0] xored;
   logic [NB-1:0][WORD_W-1:0] stored;
   logic [PW-1:0]             in_pl, out_pl;

   if (NB == NB_DEF && WORD_W == WORD_W_DEF) begin : g_pkg_xor
      assign xored = ark_xor(state_i, rk_i);
   end else begin : g_gen_xor
      assign xored = state_i ^ rk_i;
   end

`ifdef ARK_BYPASS_EN
   assign stored = bypass_i ? state_i : xored;
`else
   assign stored = xored;
`endif

   // zero flag travels with the data so it always matches state_o.
   assign in_pl = {~|stored, tag_i, stored};

   ark_skid #(
      .W(PW)
   ) u_skid (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_pl),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_pl)
   );

   assign state_o = out_pl[SW-1:0];
   assign tag_o   = out_pl[SW+TAG_W-1:SW];
   assign zero_o  = out_pl[PW-1];

endmodule

// File: tb/tb_ark_stage.sv
// Directed self-checking bench for ark_stage (default build or ARK_BYPASS_EN).
module tb_ark_stage;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [3:0][31:0] state_i;
   logic [3:0][31:0] rk_i;
   logic [3:0]     tag_i;
`ifdef ARK_BYPASS_EN
   logic           bypass_i;
`endif
   logic           out_valid;
   logic           out_ready;
   logic [3:0][31:0] state_o;
   logic [3:0]     tag_o;
   logic           zero_o;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ark_stage dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .state_i  (state_i),
      .rk_i     (rk_i),
      .tag_i    (tag_i),
`ifdef ARK_BYPASS_EN
      .bypass_i (bypass_i),
`endif
      .out_valid(out_valid),
      .out_ready(out_ready),
      .state_o  (state_o),
      .tag_o    (tag_o),
      .zero_o   (zero_o)
   );

   task automatic drive(input logic v, input logic [127:0] s, input logic [127:0] k,
                        input logic [3:0] t);
      in_valid = v;
      state_i  = s;
      rk_i     = k;
      tag_i    = t;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b0, '0, '0, 4'd0);
      out_ready = 1'b0;
`ifdef ARK_BYPASS_EN
      bypass_i = 1'b0;
`endif
      #2;
      checks++;
      if ({out_valid, state_o, tag_o, zero_o, in_ready} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got v=%b s=%h t=%h z=%b r=%b, want all zero",
                  out_valid, state_o, tag_o, zero_o, in_ready);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: got in_ready=%b out_valid=%b, want 1 0",
                  in_ready, out_valid);
      end
   endtask

   task automatic test_equal_key();
      @(negedge clk);
      out_ready = 1'b1;
      drive(1'b1, 128'h01234567_01234567_89ABCDEF_89ABCDEF,
            128'h01234567_01234567_89ABCDEF_89ABCDEF, 4'd3);
      step();
      checks++;
      if (out_valid !== 1'b1 || state_o !== '0 || zero_o !== 1'b1 || tag_o !== 4'd3) begin
         errors++;
         $display("FAIL equal_key: got v=%b s=%h z=%b t=%h, want 1 0 1 3",
                  out_valid, state_o, zero_o, tag_o);
      end
      drain();
   endtask

   task automatic test_distinct_key();
      drive(1'b1, 128'h01234567_01234567_89ABCDEF_89ABCDEF,
            128'h89ABCDEF_456789AB_0123CDEF_456789AB, 4'd9);
      step();
      checks++;
      if (state_o !== 128'h88888888_4444CCCC_88880000_CCCC4444 || zero_o !== 1'b0 ||
          tag_o !== 4'd9 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL distinct_key: got v=%b s=%h z=%b t=%h, want 1 88888888_4444cccc_88880000_cccc4444 0 9",
                  out_valid, state_o, zero_o, tag_o);
      end
      drain();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      drive(1'b1, {4{32'hA5A5A5A5}}, {4{32'h0F0F0F0F}}, 4'd5);
      step();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1 || tag_o !== 4'd5) begin
         errors++;
         $display("FAIL bp_first: got r=%b v=%b t=%h, want 1 1 5", in_ready, out_valid, tag_o);
      end
      @(negedge clk);
      drive(1'b1, {4{32'h12345678}}, {4{32'hFFFFFFFF}}, 4'd6);
      step();
      checks++;
      if (in_ready !== 1'b0 || state_o !== {4{32'hAAAAAAAA}} || tag_o !== 4'd5) begin
         errors++;
         $display("FAIL bp_full: got r=%b s=%h t=%h, want 0 aaaaaaaa.. 5", in_ready, state_o, tag_o);
      end
      @(negedge clk);
      drive(1'b1, {4{32'hDEADBEEF}}, '0, 4'd7);
      step();
      checks++;
      if (in_ready !== 1'b0 || state_o !== {4{32'hAAAAAAAA}} || tag_o !== 4'd5 ||
          zero_o !== 1'b0 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_hold: got r=%b v=%b s=%h t=%h z=%b, want 0 1 aaaaaaaa.. 5 0",
                  in_ready, out_valid, state_o, tag_o, zero_o);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b1 || state_o !== {4{32'hEDCBA987}} || tag_o !== 4'd6 ||
          in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_second: got v=%b s=%h t=%h r=%b, want 1 edcba987.. 6 1",
                  out_valid, state_o, tag_o, in_ready);
      end
      step();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_empty: got v=%b r=%b, want 0 1 (tag 7 must be dropped)",
                  out_valid, in_ready);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, {4{i[31:0]}}, '0, i[3:0]);
         step();
         checks++;
         if (out_valid !== 1'b1 || tag_o !== i[3:0] || state_o !== {4{i[31:0]}} ||
             in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stream_%0d: got v=%b t=%h r=%b, want 1 %h 1",
                     i, out_valid, tag_o, in_ready, i[3:0]);
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL stream_end: got out_valid=%b, want 0", out_valid);
      end
      drain();
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      drive(1'b1, {4{32'h11111111}}, '0, 4'd1);
      step();
      @(negedge clk);
      drive(1'b1, {4{32'h22222222}}, '0, 4'd2);
      step();
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || state_o !== '0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: got v=%b s=%h r=%b, want 0 0 0", out_valid, state_o, in_ready);
      end
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_after_%0d: got v=%b r=%b, want 0 1", i, out_valid, in_ready);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_bypass();
      out_ready = 1'b1;
`ifdef ARK_BYPASS_EN
      bypass_i = 1'b1;
`endif
      drive(1'b1, {4{32'h01234567}}, {4{32'h01234567}}, 4'd4);
      step();
      checks++;
`ifdef ARK_BYPASS_EN
      if (state_o !== {4{32'h01234567}} || zero_o !== 1'b0 || tag_o !== 4'd4) begin
         errors++;
         $display("FAIL bypass: got s=%h z=%b t=%h, want 01234567.. 0 4", state_o, zero_o, tag_o);
      end
      bypass_i = 1'b0;
`else
      if (state_o !== '0 || zero_o !== 1'b1 || tag_o !== 4'd4) begin
         errors++;
         $display("FAIL no_bypass: got s=%h z=%b t=%h, want 0 1 4", state_o, zero_o, tag_o);
      end
`endif
      drain();
   endtask

   initial begin
      test_reset();
      test_equal_key();
      test_distinct_key();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_bypass();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
